// File: rtl/muldiv_stall_controller_pkg.sv
// Shared definitions for the multiply/divide stall controller.
//
// Contents:
//    md_state_t         controller state encoding (IDLE, BUSY, DONE)
//    MD_LAT_DEFAULT     default multiply/divide unit latency in cycles
//    MD_CNT_W_DEFAULT   default width of the stall-cycle performance counter
//    md_cnt_width()     width of the latency down-counter for a given latency
package muldiv_stall_controller_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

   localparam int MD_LAT_DEFAULT   = 4;
   localparam int MD_CNT_W_DEFAULT = 32;

   // The down-counter has to hold LAT-1 at load time; sizing it for LAT
   // keeps a little headroom and matches $clog2(LAT+1).
   function automatic int md_cnt_width(input int lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/muldiv_stall_controller_if.sv
// Signal bundle between the Execute-stage pipeline/hazard logic and the
// multiply/divide stall controller.
//
// Signals:
//    MdValidE        instruction in E is MUL/DIV           (pipeline -> ctrl)
//    StallFIn        hazard-unit StallF                    (pipeline -> ctrl)
//    StallDIn        hazard-unit StallD                    (pipeline -> ctrl)
//    FlushEIn        hazard-unit FlushE                    (pipeline -> ctrl)
//    MdStart         start pulse to the iterative unit     (ctrl -> pipeline)
//    MdResultValid   unit result valid in E                (ctrl -> pipeline)
//    StallF/StallD   merged fetch/decode stalls            (ctrl -> pipeline)
//    StallE          hold E pipeline register              (ctrl -> pipeline)
//    FlushE          merged E flush                        (ctrl -> pipeline)
//    FlushM          bubble into M                         (ctrl -> pipeline)
//    MdBusy          controller not idle                   (ctrl -> pipeline)
//    StallCount      saturating stall-cycle counter        (ctrl -> pipeline)
//
// Modports: master = pipeline/hazard side, slave = controller.
interface muldiv_stall_controller_if
   import muldiv_stall_controller_pkg::*;
#(
   parameter int CNT_W = MD_CNT_W_DEFAULT
);

   logic             MdValidE;
   logic             StallFIn;
   logic             StallDIn;
   logic             FlushEIn;
   logic             MdStart;
   logic             MdResultValid;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             FlushE;
   logic             FlushM;
   logic             MdBusy;
   logic [CNT_W-1:0] StallCount;

   modport master (
      output MdValidE, StallFIn, StallDIn, FlushEIn,
      input  MdStart, MdResultValid, StallF, StallD, StallE,
             FlushE, FlushM, MdBusy, StallCount
   );

   modport slave (
      input  MdValidE, StallFIn, StallDIn, FlushEIn,
      output MdStart, MdResultValid, StallF, StallD, StallE,
             FlushE, FlushM, MdBusy, StallCount
   );

endinterface

// File: rtl/muldiv_stall_controller_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
//
// Ports:
//    clk     clock
//    clear   synchronous clear (highest priority)
//    en      count enable
//    count   current value; sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   // Count up while enabled, holding at the maximum value once reached.
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/muldiv_stall_controller.sv
// Stall controller for a fixed-latency iterative multiply/divide unit in
// the Execute stage of a 5-stage RISC-V pipeline. While the unit works the
// MUL/DIV is held in E (F/D/E stalled, bubbles into M); the controller's
// requests are merged with the hazard-unit stall/flush signals.
//
// Parameters:
//    LAT     cycles from MdStart to result valid (2..16)
//    CNT_W   width of the stall-cycle performance counter
//
// Ports:
//    clk     pipeline clock
//    rst     synchronous active-high reset
//    bus     controller side of muldiv_stall_controller_if
module muldiv_stall_controller
   import muldiv_stall_controller_pkg::*;
#(
   parameter int LAT   = MD_LAT_DEFAULT,
   parameter int CNT_W = MD_CNT_W_DEFAULT
) (
   input  logic                           clk,
   input  logic                           rst,
   muldiv_stall_controller_if.slave       bus
);

   localparam int CW = md_cnt_width(LAT);

   md_state_t     state;
   md_state_t     state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          md_hold;
   logic          md_start;
   logic          md_result_valid;

   // State and latency-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic. The counter is loaded with LAT-1 at start and the
   // move to DONE happens when it reads 1, so DONE lands exactly LAT
   // cycles after the start cycle. MdValidE is only looked at in IDLE:
   // E is frozen during BUSY, and DONE must not restart the same
   // instruction that is still sitting in E.
   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      md_hold         = 1'b0;
      md_start        = 1'b0;
      md_result_valid = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.MdValidE) begin
               md_hold    = 1'b1;
               md_start   = 1'b1;
               cnt_next   = CW'(LAT - 1);
               state_next = BUSY;
            end
         end
         BUSY: begin
            md_hold  = 1'b1;
            cnt_next = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            md_result_valid = 1'b1;
            cnt_next        = '0;
            state_next      = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // Merge with the hazard unit. The held MUL/DIV must never be flushed,
   // so the incoming flush is masked while holding; a load-use stall that
   // overlaps the hold simply ORs in.
   always_comb begin
      bus.MdStart       = md_start;
      bus.MdResultValid = md_result_valid;
      bus.StallF        = bus.StallFIn | md_hold;
      bus.StallD        = bus.StallDIn | md_hold;
      bus.StallE        = md_hold;
      bus.FlushM        = md_hold;
      bus.FlushE        = bus.FlushEIn & ~md_hold;
      bus.MdBusy        = (state != IDLE);
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_count (
      .clk   (clk),
      .clear (rst),
      .en    (md_hold),
      .count (bus.StallCount)
   );

endmodule

// File: tb/tb_muldiv_stall_controller.sv
// Directed, table-driven bench for muldiv_stall_controller (LAT=4).
// Two instances share stimulus: one with a 32-bit stall counter and one
// with a 3-bit counter used to observe saturation.
module tb_muldiv_stall_controller;
   import muldiv_stall_controller_pkg::*;

   logic clk;
   logic rst;

   muldiv_stall_controller_if #(.CNT_W(32)) bus ();
   muldiv_stall_controller_if #(.CNT_W(3))  bus_sat ();

   muldiv_stall_controller #(.LAT(4), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   muldiv_stall_controller #(.LAT(4), .CNT_W(3)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_sat.slave)
   );

   assign bus_sat.MdValidE = bus.MdValidE;
   assign bus_sat.StallFIn = bus.StallFIn;
   assign bus_sat.StallDIn = bus.StallDIn;
   assign bus_sat.FlushEIn = bus.FlushEIn;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Flag order: {MdStart, MdResultValid, StallF, StallD, StallE, FlushE, FlushM, MdBusy}
   localparam logic [7:0] F_IDLE  = 8'b0000_0000;
   localparam logic [7:0] F_START = 8'b1011_1010;
   localparam logic [7:0] F_BUSY  = 8'b0011_1011;
   localparam logic [7:0] F_DONE  = 8'b0100_0001;

   typedef struct {
      string       name;
      logic        md_valid;
      logic        stall_f_in;
      logic        stall_d_in;
      logic        flush_e_in;
      logic [7:0]  exp_flags;
      logic [31:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input string name, input logic md, input logic sf,
                                   input logic sd, input logic fe,
                                   input logic [7:0] flags, input logic [31:0] count);
      vec_t v;
      v.name       = name;
      v.md_valid   = md;
      v.stall_f_in = sf;
      v.stall_d_in = sd;
      v.flush_e_in = fe;
      v.exp_flags  = flags;
      v.exp_count  = count;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input logic md, input logic sf, input logic sd,
                                input logic fe, input logic rst_v);
      @(posedge clk);
      #1;
      bus.MdValidE = md;
      bus.StallFIn = sf;
      bus.StallDIn = sd;
      bus.FlushEIn = fe;
      rst          = rst_v;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] exp_flags,
                              input logic [31:0] exp_count);
      logic [7:0] act_flags;
      @(negedge clk);
      act_flags = {bus.MdStart, bus.MdResultValid, bus.StallF, bus.StallD,
                   bus.StallE, bus.FlushE, bus.FlushM, bus.MdBusy};
      checks++;
      if (act_flags !== exp_flags) begin
         errors++;
         $display("[TB] FAIL %s flags: got %b expected %b", name, act_flags, exp_flags);
      end
      checks++;
      if (bus.StallCount !== exp_count) begin
         errors++;
         $display("[TB] FAIL %s StallCount: got %0d expected %0d", name, bus.StallCount, exp_count);
      end
   endtask

   task automatic check_sat_count(input string name, input logic [2:0] exp_count);
      checks++;
      if (bus_sat.StallCount !== exp_count) begin
         errors++;
         $display("[TB] FAIL %s sat StallCount: got %0d expected %0d",
                  name, bus_sat.StallCount, exp_count);
      end
   endtask

   task automatic step(input string name, input logic md, input logic sf, input logic sd,
                       input logic fe, input logic rst_v,
                       input logic [7:0] flags, input logic [31:0] count);
      applyStimulus(md, sf, sd, fe, rst_v);
      checkOutput(name, flags, count);
   endtask

   initial begin
      logic sf_r;
      logic sd_r;
      logic fe_r;
      int   sat_exp;

      rst          = 1'b1;
      bus.MdValidE = 1'b0;
      bus.StallFIn = 1'b0;
      bus.StallDIn = 1'b0;
      bus.FlushEIn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state, single MUL, back-to-back MUL/DIV, load-use overlap.
      add_vec("reset_idle",  1'b0, 1'b0, 1'b0, 1'b0, F_IDLE,  0);
      add_vec("single_c0",   1'b1, 1'b0, 1'b0, 1'b0, F_START, 0);
      add_vec("single_c1",   1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  1);
      add_vec("single_c2",   1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  2);
      add_vec("single_c3",   1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  3);
      add_vec("single_c4",   1'b1, 1'b0, 1'b0, 1'b0, F_DONE,  4);
      add_vec("single_c5",   1'b0, 1'b0, 1'b0, 1'b0, F_IDLE,  4);
      add_vec("b2b_c0",      1'b1, 1'b0, 1'b0, 1'b0, F_START, 4);
      add_vec("b2b_c1",      1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  5);
      add_vec("b2b_c2",      1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  6);
      add_vec("b2b_c3",      1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  7);
      add_vec("b2b_c4",      1'b1, 1'b0, 1'b0, 1'b0, F_DONE,  8);
      add_vec("b2b_c5",      1'b1, 1'b0, 1'b0, 1'b0, F_START, 8);
      add_vec("b2b_c6",      1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  9);
      add_vec("b2b_c7",      1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  10);
      add_vec("b2b_c8",      1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  11);
      add_vec("b2b_c9",      1'b1, 1'b0, 1'b0, 1'b0, F_DONE,  12);
      add_vec("b2b_c10",     1'b0, 1'b0, 1'b0, 1'b0, F_IDLE,  12);
      add_vec("lu_c0",       1'b1, 1'b0, 1'b0, 1'b0, F_START, 12);
      add_vec("lu_c1",       1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  13);
      add_vec("lu_c2",       1'b1, 1'b1, 1'b1, 1'b1, F_BUSY,  14);
      add_vec("lu_c3",       1'b1, 1'b0, 1'b0, 1'b0, F_BUSY,  15);
      add_vec("lu_c4",       1'b1, 1'b0, 1'b0, 1'b0, F_DONE,  16);
      add_vec("lu_c5",       1'b0, 1'b1, 1'b1, 1'b1, 8'b0011_0100, 16);
      add_vec("lu_c6",       1'b0, 1'b1, 1'b0, 1'b0, 8'b0010_0000, 16);

      foreach (vecs[i]) begin
         step(vecs[i].name, vecs[i].md_valid, vecs[i].stall_f_in, vecs[i].stall_d_in,
              vecs[i].flush_e_in, 1'b0, vecs[i].exp_flags, vecs[i].exp_count);
      end

      // Reset arriving in the middle of BUSY: controller returns to IDLE,
      // counters clear, and no result pulse ever appears.
      step("rstmid_c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, F_START, 16);
      step("rstmid_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, F_BUSY,  17);
      step("rstmid_c2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, F_BUSY,  18);
      step("rstmid_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_IDLE,  0);
      check_sat_count("rstmid_c3", 3'd0);
      for (int c = 4; c < 8; c++) begin
         step($sformatf("rstmid_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_IDLE, 0);
      end

      // Three MULs: the 3-bit counter saturates at 7, the wide one keeps going.
      for (int k = 0; k < 3; k++) begin
         step($sformatf("sat%0d_c0", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, F_START, 32'(4 * k));
         for (int c = 1; c < 4; c++) begin
            step($sformatf("sat%0d_c%0d", k, c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                 F_BUSY, 32'(4 * k + c));
         end
         step($sformatf("sat%0d_c4", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, F_DONE, 32'(4 * k + 4));
         step($sformatf("sat%0d_c5", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_IDLE, 32'(4 * k + 4));
         sat_exp = (4 * (k + 1) > 7) ? 7 : 4 * (k + 1);
         check_sat_count($sformatf("sat%0d_end", k), 3'(sat_exp));
      end

      // Idle pass-through with random hazard inputs.
      for (int c = 0; c < 20; c++) begin
         sf_r = 1'($urandom_range(0, 1));
         sd_r = 1'($urandom_range(0, 1));
         fe_r = 1'($urandom_range(0, 1));
         step($sformatf("pass_c%0d", c), 1'b0, sf_r, sd_r, fe_r, 1'b0,
              {2'b00, sf_r, sd_r, 1'b0, fe_r, 2'b00}, 12);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
